pe_array_ctrl: RTL and testbench
================================

Name: pe_array_ctrl

Overview:
- Tile-level sequencer for the rate-coded (uGEMM) systolic PE array.
- Generates the edge control signals that ripple through the array's per-PE delay chain: en_i/clr_i, en_w/clr_w, en_o/clr_o and mac_done. It also generates upstream fetch requests and a reseed pulse for the shared weight RNG.
- Runs cfg_tiles back-to-back tiles. Each tile is: clear, weight load, rate-coded MAC window, drain.

Parameters:
- IWIDTH, 8, operand width; full MAC window = 2^IWIDTH cycles
- ROWS, 8, PE rows (weight shift depth, skew)
- COLS, 8, PE columns (skew)
- TWIDTH, 16, tile counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  start request, sampled only in IDLE
- cfg_cyc  in  IWIDTH  MAC window length in cycles; 0 means 2^IWIDTH
- cfg_tiles  in  TWIDTH  number of tiles to run
- en_i  out  1  input-register enable to array edge
- clr_i  out  1  input-register clear
- en_w  out  1  weight-register enable (shift)
- clr_w  out  1  weight-register clear
- en_o  out  1  accumulator enable
- clr_o  out  1  accumulator clear
- mac_done  out  1  last-MAC-cycle marker
- wght_req  out  1  upstream drives one weight row this cycle
- ifm_req  out  1  upstream drives one ifm bit column this cycle
- rng_clr  out  1  reseed weight RNG
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Moore FSM. All outputs are decoded from registered state and counters, with no combinational path from the inputs. On reset, all outputs are 0 and the FSM is in IDLE.
- States: IDLE, CLR, WLOAD, MAC, DRAIN, DONE.
- IDLE:
  - If start=1, latch cfg_cyc and cfg_tiles.
  - If cfg_tiles=0, go to DONE.
  - Otherwise go to CLR.
  - start in any other state is ignored; config is not re-sampled.
- CLR, 1 cycle: clr_i=clr_w=clr_o=1 and rng_clr=1. Then go to WLOAD.
- WLOAD, ROWS cycles: en_w=1 and wght_req=1. Then go to MAC.
- MAC, C cycles (C = cfg_cyc, or 2^IWIDTH if cfg_cyc=0):
  - en_i=en_o=1 and ifm_req=1.
  - mac_done=1 only on the final MAC cycle.
  - Then go to DRAIN.
- DRAIN, ROWS+COLS-1 cycles: all enables 0, lets the skewed wavefront and sums exit.
  - Decrement the tile counter on the last cycle.
  - If the counter is still nonzero, go to CLR; otherwise go to DONE.
- DONE, 1 cycle: done=1. Then go to IDLE.
- Phase counter: one shared down-counter, width clog2(max(2^IWIDTH, ROWS+COLS))+1. It is loaded on each state entry and exits the state when it reaches 1. No wrap is permitted.
- Tile counter: TWIDTH bits, down-counting. cfg_tiles = 2^TWIDTH-1 is legal.
- Timing: start sampled at edge t puts the FSM in CLR during cycle t+1. Cycles per tile = 1 + ROWS + C + ROWS + COLS - 1.
- Exclusivity: en_w is never high in the same cycle as en_i or en_o. Clears occur only in CLR.
- Reset mid-operation: the next cycle is IDLE with all outputs 0. No done pulse is issued; the in-flight tile is abandoned.
- busy falls in the cycle after DONE (the IDLE cycle). start is accepted in that same IDLE cycle.

Decomposition:
- Package pe_ctrl_pkg holds:
  - state_t enum {IDLE, CLR, WLOAD, MAC, DRAIN, DONE}
  - helper function to compute the phase-counter width
  - constant for the full window, 2^IWIDTH
- No sub-module is needed. The phase counter is inline. Optionally factor out a generic load/down-counter, phase_cnt.

Test Plan (ROWS=4, COLS=4, IWIDTH=8):
- Single tile: start at edge t, cfg_cyc=16, cfg_tiles=1.
  - Expect CLR at t+1, en_w at t+2..t+5, en_i/en_o at t+6..t+21, mac_done only at t+21, drain t+22..t+28, done at t+29.
  - busy high t+1..t+29.
- Full window: cfg_cyc=0 gives exactly 256 MAC cycles. mac_done is on the 256th; done at t+1+1+4+256+7.
- Multi-tile: cfg_tiles=3, cfg_cyc=8 gives three CLR pulses (three rng_clr pulses) spaced 20 cycles apart, and exactly one done.
- Zero tiles: cfg_tiles=0 gives done at t+1. No en_*, clr_* or rng_clr activity; busy high only for that cycle.
- Ignore and reset:
  - start pulsed during MAC and DRAIN is ignored, and the tile count is unchanged.
  - rst asserted mid-MAC: next cycle all outputs 0 and IDLE. A new start afterwards runs a normal full sequence.
- Back-to-back: start held high continuously gives a new CLR at (done cycle + 2) with the config re-sampled. Assertion: en_w never overlaps en_i or en_o.

Source files
------------

// File: rtl/pe_array_ctrl_pkg.sv
// Shared types and sizing helpers for the uGEMM PE-array tile sequencer.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, CLR, WLOAD, MAC, DRAIN, DONE} state_t;

  // Full rate-coded MAC window for an operand width.
  function automatic int full_win(input int iwidth);
    return 1 << iwidth;
  endfunction

  // Phase counter must hold both the full window and the drain length.
  function automatic int phase_w(input int iwidth, input int rows, input int cols);
    int m;
    m = (full_win(iwidth) > rows + cols) ? full_win(iwidth) : rows + cols;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Start/config request and array-edge control bundle of the tile sequencer.
interface pe_array_ctrl_if #(
  parameter int IWIDTH = 8,
  parameter int TWIDTH = 16
);
  logic              start;
  logic [IWIDTH-1:0] cfg_cyc;
  logic [TWIDTH-1:0] cfg_tiles;
  logic en_i, clr_i, en_w, clr_w, en_o, clr_o;
  logic mac_done, wght_req, ifm_req, rng_clr, busy, done;

  modport master (
    input  start, cfg_cyc, cfg_tiles,
    output en_i, clr_i, en_w, clr_w, en_o, clr_o,
    output mac_done, wght_req, ifm_req, rng_clr, busy, done
  );

  modport slave (
    output start, cfg_cyc, cfg_tiles,
    input  en_i, clr_i, en_w, clr_w, en_o, clr_o,
    input  mac_done, wght_req, ifm_req, rng_clr, busy, done
  );
endinterface

// File: rtl/pe_array_ctrl.sv
// Tile sequencer: clear, weight load, rate-coded MAC window and drain, repeated per tile.
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int IWIDTH = 8,
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int TWIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  pe_array_ctrl_if.master  bus
);

  localparam int PW = phase_w(IWIDTH, ROWS, COLS);
  localparam logic [PW-1:0] LEN_ONE = PW'(1);
  localparam logic [PW-1:0] LEN_W   = PW'(ROWS);
  localparam logic [PW-1:0] LEN_D   = PW'(ROWS + COLS - 1);
  localparam logic [PW-1:0] LEN_F   = PW'(full_win(IWIDTH));

  state_t            state, state_nx;
  logic [PW-1:0]     cnt, cnt_nx;
  logic [TWIDTH-1:0] tiles, tiles_nx;
  logic [IWIDTH-1:0] cyc_q;
  logic              cyc_ld;
  logic [PW-1:0]     mac_len;

  assign mac_len = (cyc_q == '0) ? LEN_F : PW'(cyc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      tiles <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tiles <= tiles_nx;
    end
  end

  // Window length is only consumed after the latch, so it carries no reset.
  always_ff @(posedge clk) begin
    if (cyc_ld) cyc_q <= bus.cfg_cyc;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tiles_nx = tiles;
    cyc_ld   = 1'b0;
    if (state == IDLE) begin
      if (bus.start) begin
        cyc_ld   = 1'b1;
        tiles_nx = bus.cfg_tiles;
        cnt_nx   = LEN_ONE;
        state_nx = (bus.cfg_tiles == '0) ? DONE : CLR;
      end
    end else if (cnt != LEN_ONE) begin
      cnt_nx = cnt - LEN_ONE;
    end else begin
      case (state)
        CLR:   begin state_nx = WLOAD; cnt_nx = LEN_W;   end
        WLOAD: begin state_nx = MAC;   cnt_nx = mac_len; end
        MAC:   begin state_nx = DRAIN; cnt_nx = LEN_D;   end
        DRAIN: begin
          tiles_nx = tiles - 1'b1;
          cnt_nx   = LEN_ONE;
          state_nx = (tiles == TWIDTH'(1)) ? DONE : CLR;
        end
        default: begin state_nx = IDLE; cnt_nx = '0; end
      endcase
    end
  end

  // Moore decode from the registered state and phase counter only.
  always_comb begin
    bus.en_i     = 1'b0;
    bus.clr_i    = 1'b0;
    bus.en_w     = 1'b0;
    bus.clr_w    = 1'b0;
    bus.en_o     = 1'b0;
    bus.clr_o    = 1'b0;
    bus.mac_done = 1'b0;
    bus.wght_req = 1'b0;
    bus.ifm_req  = 1'b0;
    bus.rng_clr  = 1'b0;
    bus.busy     = (state != IDLE);
    bus.done     = 1'b0;
    case (state)
      CLR: begin
        bus.clr_i   = 1'b1;
        bus.clr_w   = 1'b1;
        bus.clr_o   = 1'b1;
        bus.rng_clr = 1'b1;
      end
      WLOAD: begin
        bus.en_w     = 1'b1;
        bus.wght_req = 1'b1;
      end
      MAC: begin
        bus.en_i     = 1'b1;
        bus.en_o     = 1'b1;
        bus.ifm_req  = 1'b1;
        bus.mac_done = (cnt == LEN_ONE);
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Self-checking bench for pe_array_ctrl: per-cycle schedule model built from tile phase lengths.
module tb_pe_array_ctrl;

  localparam int IW = 8;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int TW = 16;

  // {en_i,clr_i,en_w,clr_w,en_o,clr_o,mac_done,wght_req,ifm_req,rng_clr,busy,done}
  localparam logic [11:0] W_IDLE  = 12'h000;
  localparam logic [11:0] W_CLR   = 12'h546;
  localparam logic [11:0] W_WLOAD = 12'h212;
  localparam logic [11:0] W_MAC   = 12'h88A;
  localparam logic [11:0] W_MACL  = 12'h8AA;
  localparam logic [11:0] W_DRAIN = 12'h002;
  localparam logic [11:0] W_DONE  = 12'h003;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pe_array_ctrl_if #(.IWIDTH(IW), .TWIDTH(TW)) bus ();

  pe_array_ctrl #(.IWIDTH(IW), .ROWS(R), .COLS(C), .TWIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  logic [11:0] obs;
  assign obs = {bus.en_i, bus.clr_i, bus.en_w, bus.clr_w, bus.en_o, bus.clr_o,
                bus.mac_done, bus.wght_req, bus.ifm_req, bus.rng_clr, bus.busy, bus.done};

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(bus.en_w && (bus.en_i || bus.en_o))) else begin
        errors++;
        $error("FAIL excl en_w=%0b en_i=%0b en_o=%0b required no overlap", bus.en_w, bus.en_i, bus.en_o);
      end
    end
  end

  task automatic check(input logic [11:0] got, input logic [11:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected per-cycle outputs for one accepted start, from CLR through DONE.
  task automatic build(input int cyc, input int tiles, output logic [11:0] q[$]);
    int win;
    q = {};
    win = (cyc == 0) ? (1 << IW) : cyc;
    for (int t = 0; t < tiles; t++) begin
      q.push_back(W_CLR);
      for (int i = 0; i < R; i++) q.push_back(W_WLOAD);
      for (int i = 0; i < win; i++) q.push_back((i == win - 1) ? W_MACL : W_MAC);
      for (int i = 0; i < R + C - 1; i++) q.push_back(W_DRAIN);
    end
    q.push_back(W_DONE);
  endtask

  // mode 0: start low during run; 1: start/config noise during run; 2: start held high.
  task automatic run(input int cyc, input int tiles, input int mode, input string tag);
    logic [11:0] q[$];
    build(cyc, tiles, q);
    bus.start     = 1'b1;
    bus.cfg_cyc   = IW'(cyc);
    bus.cfg_tiles = TW'(tiles);
    @(posedge clk); #1;
    for (int i = 0; i < q.size(); i++) begin
      check(obs, q[i], $sformatf("%s cyc%0d", tag, i + 1));
      if (mode == 1 && i < q.size() - 1) begin
        bus.start     = 1'($urandom);
        bus.cfg_cyc   = IW'($urandom);
        bus.cfg_tiles = TW'($urandom);
      end else begin
        bus.start = (mode == 2);
      end
      @(posedge clk); #1;
    end
    check(obs, W_IDLE, {tag, " idle"});
  endtask

  task automatic idle_cycles(input int n, input string tag);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check(obs, W_IDLE, tag);
    end
  endtask

  initial begin
    logic [11:0] q[$];
    int cyc, tiles, mode;
    bus.start     = 1'b0;
    bus.cfg_cyc   = '0;
    bus.cfg_tiles = '0;

    repeat (2) @(posedge clk);
    #1 check(obs, W_IDLE, "reset");
    rst = 1'b0;
    idle_cycles(2, "post_reset");

    run(16, 1, 0, "single");
    idle_cycles(2, "single_after");
    run(0, 1, 0, "fullwin");
    idle_cycles(1, "fullwin_after");
    run(8, 3, 0, "multi");
    idle_cycles(1, "multi_after");
    run(5, 0, 0, "zero");
    idle_cycles(2, "zero_after");
    run(12, 2, 1, "ignore");
    idle_cycles(1, "ignore_after");

    // Reset asserted part-way into the MAC window of the first tile.
    build(16, 2, q);
    bus.start = 1'b1; bus.cfg_cyc = 8'd16; bus.cfg_tiles = 16'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 1 + R + 5; i++) begin
      check(obs, q[i], $sformatf("pre_rst cyc%0d", i + 1));
      @(posedge clk); #1;
    end
    check(obs, q[1 + R + 5], "pre_rst mac");
    rst = 1'b1;
    @(posedge clk); #1;
    check(obs, W_IDLE, "rst_mid");
    rst = 1'b0;
    idle_cycles(4, "rst_idle");
    run(10, 1, 0, "after_rst");
    idle_cycles(1, "after_rst_idle");

    // Start held high: each DONE is followed by one IDLE cycle then a fresh CLR.
    run(6, 1, 2, "b2b_a");
    run(9, 2, 2, "b2b_b");
    run(0, 0, 2, "b2b_c");
    run(3, 1, 0, "b2b_d");
    idle_cycles(1, "b2b_after");

    for (int k = 0; k < 6; k++) begin
      cyc   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      tiles = $urandom_range(0, 3);
      mode  = $urandom_range(0, 2);
      run(cyc, tiles, mode, $sformatf("rand%0d", k));
    end
    idle_cycles(2, "final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
